// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Forwarding select encodings match the ALU operand mux in the datapath.
package hazard_pkg;

   localparam int DEF_REG_ADDR_W   = 5;
   localparam int DEF_CNT_W        = 32;
   localparam int DEF_MEM_LAT      = 1;
   localparam int DEF_BRANCH_STAGE = 3;
   localparam int WAIT_W           = 4;

   typedef enum logic {
      RUN,
      MEM_WAIT
   } state_e;

   typedef logic [1:0] fwd_t;

   localparam fwd_t FWD_REG = 2'b00;
   localparam fwd_t FWD_WB  = 2'b01;
   localparam fwd_t FWD_MEM = 2'b10;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave).
interface pipeline_hazard_ctrl_if
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = DEF_REG_ADDR_W,
   parameter int CNT_W      = DEF_CNT_W
) ();

   logic                  enable;
   logic [REG_ADDR_W-1:0] rs1_id, rs2_id;
   logic                  rs1_used_id, rs2_used_id;
   logic [REG_ADDR_W-1:0] rs1_ex, rs2_ex;
   logic [REG_ADDR_W-1:0] rd_ex, rd_mem, rd_wb;
   logic                  reg_write_ex, reg_write_mem, reg_write_wb;
   logic                  mem_read_ex;
   logic                  mem_req_mem;
   logic                  branch_taken;

   logic                  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic                  if_id_flush, id_ex_flush, ex_mem_flush;
   fwd_t                  fwd_a, fwd_b;
   logic [CNT_W-1:0]      stall_cycles, flush_events;

   modport master (
      output enable, rs1_id, rs2_id, rs1_used_id, rs2_used_id, rs1_ex, rs2_ex,
             rd_ex, rd_mem, rd_wb, reg_write_ex, reg_write_mem, reg_write_wb,
             mem_read_ex, mem_req_mem, branch_taken,
      input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             if_id_flush, id_ex_flush, ex_mem_flush, fwd_a, fwd_b,
             stall_cycles, flush_events
   );

   modport slave (
      input  enable, rs1_id, rs2_id, rs1_used_id, rs2_used_id, rs1_ex, rs2_ex,
             rd_ex, rd_mem, rd_wb, reg_write_ex, reg_write_mem, reg_write_wb,
             mem_read_ex, mem_req_mem, branch_taken,
      output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             if_id_flush, id_ex_flush, ex_mem_flush, fwd_a, fwd_b,
             stall_cycles, flush_events
   );

endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_sel.sv
// Single-operand forwarding comparator: picks the youngest in-flight producer of rs_i.
// The MEM stage holds the newer result, so it beats WB; x0 is never forwarded.
module fwd_sel
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
   input  logic [REG_ADDR_W-1:0] rs_i,
   input  logic [REG_ADDR_W-1:0] rdMem_i,
   input  logic                  regWriteMem_i,
   input  logic [REG_ADDR_W-1:0] rdWb_i,
   input  logic                  regWriteWb_i,
   output fwd_t                  sel_o
);

   always_comb begin
      sel_o = FWD_REG;
      if (regWriteMem_i && (rdMem_i != '0) && (rdMem_i == rs_i)) begin
         sel_o = FWD_MEM;
      end else if (regWriteWb_i && (rdWb_i != '0) && (rdWb_i == rs_i)) begin
         sel_o = FWD_WB;
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage pipeline.
// Priority of actions: memory freeze, then branch flush, then load-use bubble.
module pipeline_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W   = DEF_REG_ADDR_W,
   parameter int MEM_LAT      = DEF_MEM_LAT,
   parameter int BRANCH_STAGE = DEF_BRANCH_STAGE,
   parameter int CNT_W        = DEF_CNT_W
) (
   input logic                   clk,
   input logic                   srst,
   pipeline_hazard_ctrl_if.slave bus
);

   state_e             stateQ, stateD;
   logic [WAIT_W-1:0]  waitQ, waitD;
   logic               servedQ, servedD;
   logic [CNT_W-1:0]   stallQ, stallD;
   logic [CNT_W-1:0]   flushQ, flushD;

   logic loadUse, memTrigger, frozen, branchFlush;
   logic pcEn, ifIdEn, idExEn, exMemEn, memWbEn;
   logic ifIdFlush, idExFlush, exMemFlush;
   fwd_t fwdA, fwdB;

   fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) uFwdA (
      .rs_i(bus.rs1_ex), .rdMem_i(bus.rd_mem), .regWriteMem_i(bus.reg_write_mem),
      .rdWb_i(bus.rd_wb), .regWriteWb_i(bus.reg_write_wb), .sel_o(fwdA)
   );

   fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) uFwdB (
      .rs_i(bus.rs2_ex), .rdMem_i(bus.rd_mem), .regWriteMem_i(bus.reg_write_mem),
      .rdWb_i(bus.rd_wb), .regWriteWb_i(bus.reg_write_wb), .sel_o(fwdB)
   );

   // The served flag stops a finished access, still sitting in MEM, from re-freezing.
   always_comb begin
      loadUse = bus.mem_read_ex && bus.reg_write_ex && (bus.rd_ex != '0) &&
                ((bus.rs1_used_id && (bus.rs1_id == bus.rd_ex)) ||
                 (bus.rs2_used_id && (bus.rs2_id == bus.rd_ex)));
      memTrigger  = (stateQ == RUN) && bus.mem_req_mem && !servedQ && (MEM_LAT > 1);
      frozen      = (stateQ == MEM_WAIT) || memTrigger;
      branchFlush = 1'b0;
      {pcEn, ifIdEn, idExEn, exMemEn, memWbEn} = 5'b11111;
      {ifIdFlush, idExFlush, exMemFlush}       = 3'b000;
      if (srst || !bus.enable || frozen) begin
         {pcEn, ifIdEn, idExEn, exMemEn, memWbEn} = 5'b00000;
      end else if (bus.branch_taken) begin
         branchFlush = 1'b1;
         ifIdFlush   = 1'b1;
         idExFlush   = 1'b1;
         exMemFlush  = (BRANCH_STAGE == 3);
      end else if (loadUse) begin
         pcEn      = 1'b0;
         ifIdEn    = 1'b0;
         idExFlush = 1'b1;
      end
   end

   // The entry cycle is the first frozen cycle, so MEM_WAIT covers the remaining MEM_LAT-2.
   always_comb begin
      stateD  = stateQ;
      waitD   = waitQ;
      servedD = servedQ;
      stallD  = stallQ;
      flushD  = flushQ;
      if (bus.enable) begin
         case (stateQ)
            RUN: begin
               if (memTrigger) begin
                  servedD = 1'b1;
                  if (MEM_LAT > 2) begin
                     stateD = MEM_WAIT;
                     waitD  = WAIT_W'(MEM_LAT - 2);
                  end
               end
            end
            MEM_WAIT: begin
               if (waitQ <= WAIT_W'(1)) begin
                  stateD = RUN;
                  waitD  = '0;
               end else begin
                  waitD = waitQ - WAIT_W'(1);
               end
            end
            default: stateD = RUN;
         endcase
         if (exMemEn) begin
            servedD = 1'b0;
         end
         if (!pcEn && (stallQ != '1)) begin
            stallD = stallQ + CNT_W'(1);
         end
         if (branchFlush && (flushQ != '1)) begin
            flushD = flushQ + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         stateQ  <= RUN;
         waitQ   <= '0;
         servedQ <= 1'b0;
         stallQ  <= '0;
         flushQ  <= '0;
      end else begin
         stateQ  <= stateD;
         waitQ   <= waitD;
         servedQ <= servedD;
         stallQ  <= stallD;
         flushQ  <= flushD;
      end
   end

   assign bus.pc_en        = pcEn;
   assign bus.if_id_en     = ifIdEn;
   assign bus.id_ex_en     = idExEn;
   assign bus.ex_mem_en    = exMemEn;
   assign bus.mem_wb_en    = memWbEn;
   assign bus.if_id_flush  = ifIdFlush;
   assign bus.id_ex_flush  = idExFlush;
   assign bus.ex_mem_flush = exMemFlush;
   assign bus.fwd_a        = srst ? FWD_REG : fwdA;
   assign bus.fwd_b        = srst ? FWD_REG : fwdB;
   assign bus.stall_cycles = stallQ;
   assign bus.flush_events = flushQ;

endmodule
